// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - host instruction/load handshake bundle for alu_seq_ctrl
//
// Purpose: groups the two host-side valid/ready channels of the sequencer.
// Signals:
//   instr_valid/instr_ready  instruction handshake, fields instr_op/rd/rs/rt
//   ld_valid/ld_ready        register preload handshake, fields ld_addr/ld_data
// Modports: master = host driving requests, slave = sequencer answering ready.
interface alu_seq_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs;
  logic [1:0] instr_rt;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
    output ld_valid, ld_addr, ld_data,
    input  instr_ready, ld_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt,
    input  ld_valid, ld_addr, ld_data,
    output instr_ready, ld_ready
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - instruction sequencer wrapping an external 8-bit ALU
//
// Purpose: accepts instructions, presents registered operands to the ALU,
// waits EXEC_CYCLES settle cycles, then writes back the result and flags.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   host (slave)      instruction and register-load handshakes
//   rd_addr/rd_data   combinational register-file observation port
//   alu_a/b/op        registered ALU operands and op_sel
//   alu_result, alu_c/z/n/ov  ALU outputs
//   flags             {C,Z,N,OV} of last legal instruction
//   done/err          retire pulse, err marks an illegal op
//   busy              not IDLE
//   instr_count       retired instruction count (wraps)
module alu_seq_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_seq_ctrl_if.slave     host,
  input  logic [1:0]        rd_addr,
  output logic [7:0]        rd_data,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  input  logic [7:0]        alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_ov,
  output logic [3:0]        flags,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [7:0]        instr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [3:0] CNT_INIT  = 4'(EXEC_CYCLES);
  localparam logic [3:0] CNT_START = 4'(EXEC_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q;
  logic [7:0] rf_q [4];
  logic [7:0] alu_a_q, alu_b_q;
  logic [3:0] alu_op_q;
  logic [1:0] rd_sel_q;
  logic       illegal_q;
  logic [7:0] res_q;
  logic [3:0] hflags_q;
  logic [3:0] flags_q;
  logic [7:0] count_q;

  logic ld_fire, instr_fire;

  always_comb begin
    host.ld_ready    = (state_q == S_IDLE);
    // Loads win over instructions so the register file never changes under
    // an instruction that is being accepted in the same cycle.
    host.instr_ready = (state_q == S_IDLE) && !host.ld_valid;
    ld_fire          = host.ld_valid && host.ld_ready;
    instr_fire       = host.instr_valid && host.instr_ready;

    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_fire) state_d = S_EXEC;
      S_EXEC:  if (cnt_q == 4'd0) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_INIT;
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
      alu_a_q   <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_op_q  <= 4'h0;
      rd_sel_q  <= 2'd0;
      illegal_q <= 1'b0;
      res_q     <= 8'h00;
      hflags_q  <= 4'h0;
      flags_q   <= 4'h0;
      count_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (ld_fire) begin
            rf_q[host.ld_addr] <= host.ld_data;
          end else if (instr_fire) begin
            // Operands are sampled here, so rd==rs/rt sees the old value.
            alu_a_q   <= rf_q[host.instr_rs];
            alu_b_q   <= rf_q[host.instr_rt];
            alu_op_q  <= host.instr_op;
            rd_sel_q  <= host.instr_rd;
            illegal_q <= (host.instr_op >= 4'd9);
            cnt_q     <= CNT_START;
          end
        end
        S_EXEC: begin
          if (cnt_q == 4'd0) begin
            res_q    <= alu_result;
            hflags_q <= {alu_c, alu_z, alu_n, alu_ov};
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_WB: begin
          count_q <= count_q + 8'd1;
          if (!illegal_q) begin
            rf_q[rd_sel_q] <= res_q;
            flags_q        <= hflags_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data     = rf_q[rd_addr];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign flags       = flags_q;
  assign done        = (state_q == S_WB);
  assign err         = (state_q == S_WB) && illegal_q;
  assign busy        = (state_q != S_IDLE);
  assign instr_count = count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard testbench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  localparam int EXEC_CYCLES = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op, flags;
  logic       alu_c, alu_z, alu_n, alu_ov;
  logic       done, err, busy;
  logic [7:0] instr_count;

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .rst(rst), .host(bus.slave),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_ov(alu_ov),
    .flags(flags), .done(done), .err(err), .busy(busy), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // ALU behaviour: returns {C,Z,N,OV,result}; illegal ops give junk.
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic c, ov;
    c = 1'b0; ov = 1'b0; r = 8'h00; w = 9'h000;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a;
      4'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      4'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      4'd7: begin w = {1'b0, b} + 9'd1; r = w[7:0]; c = w[8]; ov = (b == 8'h7F); end
      4'd8: begin w = {1'b0, b} - 9'd1; r = w[7:0]; c = w[8]; ov = (b == 8'h80); end
      default: return 12'hFEE;
    endcase
    return {c, (r == 8'h00), r[7], ov, r};
  endfunction

  logic [11:0] alu_out;
  always_comb begin
    alu_out    = alu_f(alu_op, alu_a, alu_b);
    alu_result = alu_out[7:0];
    {alu_c, alu_z, alu_n, alu_ov} = alu_out[11:8];
  end

  typedef struct {
    logic [1:0] rd;
    logic [7:0] reg_val;
    logic [3:0] flg;
    logic       is_err;
    logic [7:0] cnt;
    int         acc_cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] m_rf [4];
  logic [3:0] m_flags;
  int         m_cnt;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic       use_stim = 1'b0;
  logic [1:0] stim_rd = 2'd0;
  logic [1:0] mon_rd = 2'd0;
  logic       mon_pend = 1'b0;
  assign rd_addr = use_stim ? stim_rd : mon_rd;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_flags = 4'h0;
    m_cnt   = 0;
  endtask

  function automatic exp_t model_instr(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [1:0] rt);
    exp_t e;
    logic [11:0] f;
    f = alu_f(op, m_rf[rs], m_rf[rt]);
    e.is_err = (op >= 4'd9);
    if (!e.is_err) begin
      m_rf[rd] = f[7:0];
      m_flags  = f[11:8];
    end
    m_cnt     = (m_cnt + 1) % 256;
    e.rd      = rd;
    e.reg_val = m_rf[rd];
    e.flg     = m_flags;
    e.cnt     = 8'(m_cnt);
    e.acc_cyc = cyc;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops an expectation on every done and checks the retire results
  // one cycle later, once writeback has landed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        chk("wb_reg", int'(rd_data), int'(e.reg_val));
        chk("wb_flags", int'(flags), int'(e.flg));
        chk("wb_count", int'(instr_count), int'(e.cnt));
        mon_pend = 1'b0;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("err_pulse", int'(err), int'(e.is_err));
          chk("done_latency", cyc - e.acc_cyc, EXEC_CYCLES + 1);
          mon_rd   = e.rd;
          mon_pend = 1'b1;
        end
      end
    end
  end

  task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
    int n;
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_data = data;
    #1; n = 0;
    while (!bus.ld_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!bus.ld_ready) begin
      chk("load_accept_timeout", 0, 1);
      bus.ld_valid = 1'b0;
      return;
    end
    m_rf[addr] = data;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs, input logic [1:0] rt);
    int n;
    @(negedge clk);
    bus.instr_valid = 1'b1; bus.instr_op = op;
    bus.instr_rd = rd; bus.instr_rs = rs; bus.instr_rt = rt;
    #1; n = 0;
    while (!bus.instr_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!bus.instr_ready) begin
      chk("instr_accept_timeout", 0, 1);
      bus.instr_valid = 1'b0;
      return;
    end
    sbq.push_back(model_instr(op, rd, rs, rt));
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk("busy_exec", int'(busy), 1);
    chk("alu_op_exec", int'(alu_op), int'(op));
    chk("ld_ready_busy", int'(bus.ld_ready), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sbq.size() != 0 || mon_pend) && n < 200) begin @(negedge clk); n++; end
    if (busy || sbq.size() != 0 || mon_pend) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic read_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    use_stim = 1'b1; stim_rd = a;
    #1;
    chk(name, int'(rd_data), int'(exp));
    use_stim = 1'b0;
  endtask

  initial begin
    bus.instr_valid = 1'b0; bus.instr_op = 4'h0;
    bus.instr_rd = 2'd0; bus.instr_rs = 2'd0; bus.instr_rt = 2'd0;
    bus.ld_valid = 1'b0; bus.ld_addr = 2'd0; bus.ld_data = 8'h00;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_count", int'(instr_count), 0);

    // add, sub to zero, signed overflow with rd==rs
    do_load(2'd0, 8'h05); do_load(2'd1, 8'h03);
    do_instr(4'd0, 2'd2, 2'd0, 2'd1);
    wait_idle();
    read_reg("add_r2", 2'd2, 8'h08);
    do_load(2'd0, 8'h03);
    do_instr(4'd1, 2'd3, 2'd0, 2'd1);
    wait_idle();
    chk("sub_zflag", int'(flags[2]), 1);
    do_load(2'd0, 8'h7F); do_load(2'd1, 8'h01);
    do_instr(4'd0, 2'd0, 2'd0, 2'd1);
    wait_idle();
    read_reg("ovf_r0", 2'd0, 8'h80);
    chk("ovf_flags", int'(flags), 4'b0011);

    // simultaneous load and instruction: load first
    @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 8'h22;
    bus.instr_valid = 1'b1; bus.instr_op = 4'd0;
    bus.instr_rd = 2'd3; bus.instr_rs = 2'd1; bus.instr_rt = 2'd0;
    #1;
    chk("prio_instr_ready", int'(bus.instr_ready), 0);
    chk("prio_ld_ready", int'(bus.ld_ready), 1);
    m_rf[1] = 8'h22;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    #1;
    chk("prio_instr_next", int'(bus.instr_ready), 1);
    sbq.push_back(model_instr(4'd0, 2'd3, 2'd1, 2'd0));
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk("prio_busy", int'(busy), 1);
    chk("prio_ld_ready_busy", int'(bus.ld_ready), 0);
    wait_idle();

    // illegal op leaves state untouched
    do_instr(4'hC, 2'd2, 2'd0, 2'd1);
    wait_idle();

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      else
        do_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    wait_idle();

    // reset during EXEC aborts the instruction
    do_load(2'd2, 8'h11);
    do_instr(4'd4, 2'd1, 2'd2, 2'd2);
    rst = 1'b1;
    sbq.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_flags", int'(flags), 0);
    chk("abort_count", int'(instr_count), 0);
    chk("abort_alu_a", int'(alu_a), 0);
    for (int i = 0; i < 4; i++) read_reg("abort_reg", 2'(i), 8'h00);
    repeat (3) @(negedge clk);

    // 256 retires wrap the counter
    for (int i = 0; i < 256; i++)
      do_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    wait_idle();
    chk("count_wrap", int'(instr_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
